// File: rtl/rst_seq_ctrl_pkg.sv
// rst_seq_ctrl_pkg: FSM state encoding and width helper shared by the reset sequencer.
package rst_seq_ctrl_pkg;
    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_ASSERT   = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_GAP      = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    // Bits needed to encode 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rst_sync_2ff.sv
// rst_sync_2ff: W-bit two-flop level synchronizer with asynchronous active-low clear to 0.
module rst_sync_2ff #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: holds all domain resets, then releases them in index order gated by each domain's ready.
// Define RST_SEQ_RDY_MON_EN to fault when any ready drops while in DONE.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 8,
    parameter int TMO_CYC  = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_sw_rst,
    input  logic [N_DOM-1:0]           i_dom_rdy,
    output logic [N_DOM-1:0]           o_dom_rst,
    output logic                       o_busy,
    output logic                       o_all_ready,
    output logic                       o_fault,
    output logic [width_of(N_DOM)-1:0] o_fault_dom
);
    localparam int IDX_W   = width_of(N_DOM);
    localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? ((HOLD_CYC > TMO_CYC) ? HOLD_CYC : TMO_CYC)
                                                  : ((GAP_CYC > TMO_CYC) ? GAP_CYC : TMO_CYC);
    localparam int CNT_W   = width_of(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(TMO_CYC - 1);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(N_DOM - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   fault_dom_q, fault_dom_d;
    logic [N_DOM-1:0]   dom_rst_q, dom_rst_d;
    logic               fault_q, fault_d;
    logic               all_ready_q, all_ready_d;
    logic [N_DOM-1:0]   rdy_s;

    rst_sync_2ff #(.W(N_DOM)) u_rdy_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_dom_rdy),
        .o_q     (rdy_s)
    );

`ifdef RST_SEQ_RDY_MON_EN
    logic             rdy_drop;
    logic [IDX_W-1:0] drop_idx;

    assign rdy_drop = ~&rdy_s;

    always_comb begin
        drop_idx = '0;
        for (int i = N_DOM - 1; i >= 0; i--)
            if (!rdy_s[i]) drop_idx = IDX_W'(i);
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_rst_q   <= '1;
            fault_q     <= 1'b0;
            fault_dom_q <= '0;
            all_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dom_rst_q   <= dom_rst_d;
            fault_q     <= fault_d;
            fault_dom_q <= fault_dom_d;
            all_ready_q <= all_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == HOLD_END) begin
                    state_d = ST_WAIT_RDY;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RDY: begin
                // Ready takes priority over a coincident timeout.
                if (rdy_s[idx_q]) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_END) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = (idx_q == LAST) ? ST_DONE : ST_WAIT_RDY;
                    idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
`ifdef RST_SEQ_RDY_MON_EN
                if (rdy_drop) state_d = ST_FAULT;
`endif
            end
            default: cnt_d = '0;
        endcase
        if (i_sw_rst) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    always_comb begin
        dom_rst_d   = dom_rst_q;
        fault_d     = fault_q;
        fault_dom_d = fault_dom_q;
        // Each WAIT_RDY entry releases exactly the domain being waited on.
        if (state_d == ST_FAULT && state_q != ST_FAULT) begin
            dom_rst_d = '1;
            fault_d   = 1'b1;
`ifdef RST_SEQ_RDY_MON_EN
            fault_dom_d = (state_q == ST_DONE) ? drop_idx : idx_q;
`else
            fault_dom_d = idx_q;
`endif
        end else if (state_d == ST_WAIT_RDY && state_q != ST_WAIT_RDY) begin
            dom_rst_d = dom_rst_q & ~(N_DOM'(1) << idx_d);
        end
        if (i_sw_rst) begin
            dom_rst_d = '1;
            fault_d   = 1'b0;
        end
        all_ready_d = (state_q == ST_DONE) && (state_d == ST_DONE) && (&rdy_s);
    end

    assign o_busy      = (state_q == ST_ASSERT) || (state_q == ST_WAIT_RDY) || (state_q == ST_GAP);
    assign o_dom_rst   = dom_rst_q;
    assign o_all_ready = all_ready_q;
    assign o_fault     = fault_q;
    assign o_fault_dom = fault_dom_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed bench for rst_seq_ctrl (N_DOM=4, HOLD=16, GAP=8, TMO=64).
// Honours RST_SEQ_RDY_MON_EN when choosing the expectations for a ready drop in DONE.
module tb_rst_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst = 1'b0;
    logic [3:0] dom_rdy = 4'b0000;
    logic [3:0] dom_rst;
    logic       busy;
    logic       all_ready;
    logic       fault;
    logic [1:0] fault_dom;
    int         checks = 0;
    int         failures = 0;

    rst_seq_ctrl #(
        .N_DOM    (4),
        .HOLD_CYC (16),
        .GAP_CYC  (8),
        .TMO_CYC  (64)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sw_rst    (sw_rst),
        .i_dom_rdy   (dom_rdy),
        .o_dom_rst   (dom_rst),
        .o_busy      (busy),
        .o_all_ready (all_ready),
        .o_fault     (fault),
        .o_fault_dom (fault_dom)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Leaves time at 1ns past the n-th rising edge from now.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sw();
        sw_rst  = 1'b1;
        dom_rdy = 4'b0000;
        tick(1);
        sw_rst = 1'b0;
        check("sw_rst", dom_rst, 4'hf);
        check("sw_busy", busy, 1);
        check("sw_fault", fault, 0);
        check("sw_ar", all_ready, 0);
    endtask

    // Starts 1ns after the edge that put the FSM in ASSERT with cnt=0.
    // fail_dom never gets ready; abort_dom gets a software reset mid-GAP.
    task automatic seq(input int fail_dom, input int abort_dom);
        logic [3:0] mask;
        mask = 4'b1111;
        tick(15);
        check("hold", dom_rst, 4'hf);
        tick(1);
        mask[0] = 1'b0;
        check("rel0", dom_rst, mask);
        check("busy_wait", busy, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == fail_dom) begin
                tick(63);
                check("pre_tmo", fault, 0);
                tick(1);
                check("tmo_fault", fault, 1);
                check("tmo_dom", fault_dom, k);
                check("tmo_rst", dom_rst, 4'hf);
                check("tmo_busy", busy, 0);
                return;
            end
            tick(4);
            dom_rdy[k] = 1'b1;
            if (k == abort_dom) begin
                tick(5);
                check("gap_busy", busy, 1);
                pulse_sw();
                return;
            end
            tick(10);
            check("pre_rel", dom_rst, mask);
            tick(1);
            if (k < 3) begin
                mask[k+1] = 1'b0;
                check("rel", dom_rst, mask);
            end else begin
                check("done_rst", dom_rst, 4'h0);
                check("done_busy", busy, 0);
                check("ar_lag", all_ready, 0);
                tick(1);
                check("all_ready", all_ready, 1);
            end
        end
    endtask

    initial begin
        tick(3);
        check("rst_dom", dom_rst, 4'hf);
        check("rst_busy", busy, 1);
        check("rst_ar", all_ready, 0);
        check("rst_fault", fault, 0);
        check("rst_fdom", fault_dom, 0);
        rst_n = 1'b1;

        seq(-1, -1);

        // Ready drop of domain 1 for three cycles while in DONE.
        dom_rdy[1] = 1'b0;
        tick(1);
        check("drop_ar1", all_ready, 1);
        tick(1);
        check("drop_ar2", all_ready, 1);
        tick(1);
        dom_rdy[1] = 1'b1;
`ifdef RST_SEQ_RDY_MON_EN
        check("mon_fault", fault, 1);
        check("mon_dom", fault_dom, 1);
        check("mon_rst", dom_rst, 4'hf);
        tick(3);
        check("mon_sticky", fault, 1);
`else
        check("drop_ar3", all_ready, 0);
        tick(2);
        check("drop_ar5", all_ready, 0);
        tick(1);
        check("drop_ar6", all_ready, 1);
        check("drop_fault", fault, 0);
        check("drop_rst", dom_rst, 4'h0);
`endif

        pulse_sw();
        seq(-1, 1);
        seq(2, -1);
        pulse_sw();
        seq(-1, -1);

        // Asynchronous reset between edges while waiting on domain 0.
        pulse_sw();
        tick(16);
        check("t5_rel0", dom_rst, 4'he);
        tick(3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_dom", dom_rst, 4'hf);
        check("async_busy", busy, 1);
        check("async_ar", all_ready, 0);
        check("async_fault", fault, 0);
        check("async_fdom", fault_dom, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
